// File: rtl/tpu_csr_v2.sv
// tpu_csr_v2: MMIO register block and run sequencer for the systolic TPU.
// Decodes CSRs, drives the A/B buffer write port and reads back A/B/C.
module tpu_csr_v2 #(
    parameter int          N             = 4,
    parameter int          DATA_W        = 8,
    parameter int          SUM_W         = 32,
    parameter logic [31:0] ID_VALUE      = 32'h5450_0002,
    parameter logic [31:0] VERSION_VALUE = 32'h0002_0000,
    parameter logic [15:0] TPU_BASE      = 16'h0000,
    parameter int          RUN_LEN_RST   = 4 * N,
    localparam int         NE            = N * N,
    localparam int         AW            = (NE > 1) ? $clog2(NE) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mmio_wr,
    input  logic                 mmio_rd,
    input  logic [15:0]          mmio_addr,
    input  logic [31:0]          mmio_wdata,
    input  logic [3:0]           mmio_wstrb,
    input  logic [DATA_W*NE-1:0] a_flat,
    input  logic [DATA_W*NE-1:0] b_flat,
    input  logic [SUM_W*NE-1:0]  c_flat,
    output logic [31:0]          mmio_rdata,
    output logic                 mmio_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 irq,
    output logic                 capture_sums,
    output logic [15:0]          t_ctr,
    output logic [1:0]           state,
    output logic                 we_a,
    output logic                 we_b,
    output logic [AW-1:0]        addr_a,
    output logic [AW-1:0]        addr_b,
    output logic [DATA_W-1:0]    wdata_a,
    output logic [DATA_W-1:0]    wdata_b
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        CAPT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        st;
    logic [15:0]   off;
    logic [15:0]   run_len;
    logic [15:0]   len_q;
    logic [15:0]   eff_len;
    logic [31:0]   cycles;
    logic          irq_en;
    logic          err_start;
    logic          err_wr;

    logic          buf_hit;
    logic          sel_id;
    logic          sel_ver;
    logic          sel_ctrl;
    logic          sel_stat;
    logic          sel_len;
    logic          sel_cyc;
    logic          sel_a;
    logic          sel_b;
    logic          sel_c;
    logic [AW-1:0] idx;

    logic          wr_ctrl;
    logic          wr_stat;
    logic          start_req;
    logic          clear_req;
    logic          start_err;
    logic          buf_wr_err;

    logic [31:0]   a_ext;
    logic [31:0]   b_ext;
    logic [31:0]   c_ext;
    logic [31:0]   rd_mux;
    logic          unused_bits;

    // Address decode relative to the block base
    assign off      = mmio_addr - TPU_BASE;
    assign sel_id   = (off == 16'h0000);
    assign sel_ver  = (off == 16'h0004);
    assign sel_ctrl = (off == 16'h0008);
    assign sel_stat = (off == 16'h000C);
    assign sel_len  = (off == 16'h0010);
    assign sel_cyc  = (off == 16'h0014);
    assign buf_hit  = (off[1:0] == 2'b00)
                   && ({1'b0, off[7:0]} < 9'(4 * NE));
    assign sel_a    = buf_hit && (off[15:8] == 8'h01);
    assign sel_b    = buf_hit && (off[15:8] == 8'h02);
    assign sel_c    = buf_hit && (off[15:8] == 8'h03);
    assign idx      = off[AW+1:2];

    // Command and error qualifiers for this cycle's access
    assign wr_ctrl    = mmio_wr && sel_ctrl && mmio_wstrb[0];
    assign wr_stat    = mmio_wr && sel_stat && mmio_wstrb[0];
    assign start_req  = wr_ctrl && mmio_wdata[0];
    assign clear_req  = wr_ctrl && mmio_wdata[1];
    assign start_err  = start_req && ((st == RUN) || (st == CAPT));
    assign buf_wr_err = mmio_wr && (sel_a || sel_b) && busy;
    assign eff_len    = (run_len == 16'd0) ? 16'd1 : run_len;

    // Buffer write port is combinational so the array sees it this cycle
    assign we_a    = mmio_wr && sel_a && mmio_wstrb[0] && !busy;
    assign we_b    = mmio_wr && sel_b && mmio_wstrb[0] && !busy;
    assign addr_a  = idx;
    assign addr_b  = idx;
    assign wdata_a = mmio_wdata[DATA_W-1:0];
    assign wdata_b = mmio_wdata[DATA_W-1:0];

    assign irq   = done && irq_en;
    assign state = st;

    assign unused_bits = ^{mmio_wdata[31:16], mmio_wstrb[3:2]};

    // Read data mux, zero-extending buffer elements
    always_comb begin
        a_ext  = 32'(a_flat[int'(idx)*DATA_W +: DATA_W]);
        b_ext  = 32'(b_flat[int'(idx)*DATA_W +: DATA_W]);
        c_ext  = 32'(c_flat[int'(idx)*SUM_W +: SUM_W]);
        rd_mux = '0;
        unique case (1'b1)
            sel_id:   rd_mux = ID_VALUE;
            sel_ver:  rd_mux = VERSION_VALUE;
            sel_ctrl: rd_mux = {29'd0, irq_en, 2'b00};
            sel_stat: rd_mux = {28'd0, err_wr, err_start, done, busy};
            sel_len:  rd_mux = {16'd0, run_len};
            sel_cyc:  rd_mux = cycles;
            sel_a:    rd_mux = a_ext;
            sel_b:    rd_mux = b_ext;
            sel_c:    rd_mux = c_ext;
            default:  rd_mux = '0;
        endcase
    end

    // Bus response: one-cycle ready pulse with registered read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mmio_ready <= 1'b0;
            mmio_rdata <= '0;
        end else begin
            mmio_ready <= mmio_wr || mmio_rd;
            mmio_rdata <= mmio_rd ? rd_mux : 32'd0;
        end
    end

    // Writable CSR fields; a new error wins over a same-cycle W1C
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_len   <= 16'(RUN_LEN_RST);
            irq_en    <= 1'b0;
            err_start <= 1'b0;
            err_wr    <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                irq_en <= mmio_wdata[2];
            end
            if (mmio_wr && sel_len && !busy) begin
                if (mmio_wstrb[0]) begin
                    run_len[7:0] <= mmio_wdata[7:0];
                end
                if (mmio_wstrb[1]) begin
                    run_len[15:8] <= mmio_wdata[15:8];
                end
            end
            err_start <= start_err
                      || (err_start && !(wr_stat && mmio_wdata[2]));
            err_wr    <= buf_wr_err
                      || (err_wr && !(wr_stat && mmio_wdata[3]));
        end
    end

    // Run sequencer: IDLE/DONE -> RUN (len cycles) -> CAPT -> DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st           <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            capture_sums <= 1'b0;
            t_ctr        <= '0;
            len_q        <= 16'd1;
            cycles       <= '0;
        end else begin
            unique case (st)
                IDLE, DONE: begin
                    if (start_req) begin
                        st    <= RUN;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        t_ctr <= '0;
                        len_q <= eff_len;
                    end else if (clear_req) begin
                        st   <= IDLE;
                        done <= 1'b0;
                    end
                end
                RUN: begin
                    if (t_ctr == len_q - 16'd1) begin
                        st           <= CAPT;
                        busy         <= 1'b0;
                        t_ctr        <= '0;
                        capture_sums <= 1'b1;
                    end else begin
                        t_ctr <= t_ctr + 16'd1;
                    end
                end
                CAPT: begin
                    st           <= DONE;
                    capture_sums <= 1'b0;
                    done         <= 1'b1;
                    cycles       <= {16'd0, len_q} + 32'd1;
                end
                default: begin
                    st <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tpu_csr_v2.sv
// tb_tpu_csr_v2: directed and randomized bench for tpu_csr_v2.
// Expected values come from a register/run model kept in this file.
module tb_tpu_csr_v2;

    localparam int N      = 4;
    localparam int DATA_W = 8;
    localparam int SUM_W  = 32;
    localparam int NE     = N * N;
    localparam int AW     = $clog2(NE);

    logic                 clk        = 1'b0;
    logic                 rst_n      = 1'b0;
    logic                 mmio_wr    = 1'b0;
    logic                 mmio_rd    = 1'b0;
    logic [15:0]          mmio_addr  = '0;
    logic [31:0]          mmio_wdata = '0;
    logic [3:0]           mmio_wstrb = '0;
    logic [DATA_W*NE-1:0] a_flat;
    logic [DATA_W*NE-1:0] b_flat;
    logic [SUM_W*NE-1:0]  c_flat;
    logic [31:0]          mmio_rdata;
    logic                 mmio_ready;
    logic                 busy;
    logic                 done;
    logic                 irq;
    logic                 capture_sums;
    logic [15:0]          t_ctr;
    logic [1:0]           state;
    logic                 we_a;
    logic                 we_b;
    logic [AW-1:0]        addr_a;
    logic [AW-1:0]        addr_b;
    logic [DATA_W-1:0]    wdata_a;
    logic [DATA_W-1:0]    wdata_b;

    tpu_csr_v2 #(.N(N), .DATA_W(DATA_W), .SUM_W(SUM_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .mmio_wr(mmio_wr), .mmio_rd(mmio_rd),
        .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata),
        .mmio_wstrb(mmio_wstrb),
        .a_flat(a_flat), .b_flat(b_flat), .c_flat(c_flat),
        .mmio_rdata(mmio_rdata), .mmio_ready(mmio_ready),
        .busy(busy), .done(done), .irq(irq),
        .capture_sums(capture_sums), .t_ctr(t_ctr), .state(state),
        .we_a(we_a), .we_b(we_b),
        .addr_a(addr_a), .addr_b(addr_b),
        .wdata_a(wdata_a), .wdata_b(wdata_b)
    );

    always #5 clk = ~clk;

    // Reference model: buffer contents and architectural CSR state
    logic [DATA_W-1:0] abuf [NE];
    logic [DATA_W-1:0] bbuf [NE];
    logic [SUM_W-1:0]  cbuf [NE];
    logic [15:0]       m_len;
    logic              m_irq_en;
    logic              m_done;
    logic              m_busy;
    logic              m_err_start;
    logic              m_err_wr;

    for (genvar g = 0; g < NE; g++) begin : g_flat
        assign a_flat[g*DATA_W +: DATA_W] = abuf[g];
        assign b_flat[g*DATA_W +: DATA_W] = bbuf[g];
        assign c_flat[g*SUM_W +: SUM_W]   = cbuf[g];
    end

    int vectors     = 0;
    int miscompares = 0;

    logic              s_we_a;
    logic              s_we_b;
    logic [AW-1:0]     s_addr_a;
    logic [AW-1:0]     s_addr_b;
    logic [DATA_W-1:0] s_wdata_a;
    logic [DATA_W-1:0] s_wdata_b;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic bus(input logic wr, input logic rd,
                       input logic [15:0] addr, input logic [31:0] wd,
                       input logic [3:0] strb, output logic [31:0] rdv);
        @(negedge clk);
        mmio_wr    = wr;
        mmio_rd    = rd;
        mmio_addr  = addr;
        mmio_wdata = wd;
        mmio_wstrb = strb;
        #1;
        s_we_a    = we_a;
        s_we_b    = we_b;
        s_addr_a  = addr_a;
        s_addr_b  = addr_b;
        s_wdata_a = wdata_a;
        s_wdata_b = wdata_b;
        @(negedge clk);
        mmio_wr    = 1'b0;
        mmio_rd    = 1'b0;
        mmio_wstrb = '0;
        chk("mmio_ready", 32'(mmio_ready), 32'd1);
        rdv = mmio_rdata;
        if (!rd) chk("rdata_idle", rdv, 32'd0);
    endtask

    task automatic wrs(input logic [15:0] addr, input logic [31:0] wd,
                       input logic [3:0] strb);
        logic [31:0] unused_rd;
        bus(1'b1, 1'b0, addr, wd, strb, unused_rd);
    endtask

    task automatic wr32(input logic [15:0] addr, input logic [31:0] wd);
        wrs(addr, wd, 4'hF);
    endtask

    task automatic rd_chk(input string tag, input logic [15:0] addr,
                          input logic [31:0] exp);
        logic [31:0] v;
        bus(1'b0, 1'b1, addr, 32'd0, 4'h0, v);
        chk(tag, v, exp);
    endtask

    function automatic logic [31:0] status_exp();
        return {28'd0, m_err_wr, m_err_start, m_done, m_busy};
    endfunction

    function automatic int eff_len(input logic [15:0] len);
        return (len == 16'd0) ? 1 : int'(len);
    endfunction

    task automatic start_run(input logic [31:0] ctrl);
        wr32(16'h0008, ctrl);
        m_irq_en = ctrl[2];
        if (ctrl[0]) begin
            m_busy = 1'b1;
            m_done = 1'b0;
        end else if (ctrl[1]) begin
            m_done = 1'b0;
        end
    endtask

    // Run observed from the first cycle after the start write:
    // len busy cycles, one capture cycle, then done.
    task automatic run_check();
        int L;
        int busy_n;
        int cap_n;
        int done_k;
        logic [15:0] t_last;
        logic [1:0]  st_capt;
        L      = eff_len(m_len);
        busy_n = 0;
        cap_n  = 0;
        done_k = 0;
        t_last = 16'hFFFF;
        st_capt = 2'b00;
        for (int k = 1; k <= L + 40; k++) begin
            if (k > 1) @(negedge clk);
            busy_n += int'(busy);
            cap_n  += int'(capture_sums);
            if (k == L) t_last = t_ctr;
            if (k == L + 1) st_capt = state;
            if (done) begin
                done_k = k;
                break;
            end
        end
        chk("run_busy_cycles", 32'(busy_n), 32'(L));
        chk("run_capture_pulses", 32'(cap_n), 32'd1);
        chk("run_done_latency", 32'(done_k), 32'(L + 2));
        chk("run_t_ctr_last", 32'(t_last), 32'(L - 1));
        chk("run_state_capt", 32'(st_capt), 32'd2);
        m_busy = 1'b0;
        m_done = 1'b1;
        chk("run_irq", 32'(irq), 32'(m_done & m_irq_en));
        rd_chk("run_cycles", 16'h0014, 32'(L + 1));
        rd_chk("run_status", 16'h000C, status_exp());
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("done_within_budget", 32'(done), 32'd1);
        m_busy = 1'b0;
        m_done = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          idx;
        int          cnt;
        logic [31:0] d;
        logic [31:0] v;
        logic        pick_b;
        logic [15:0] addr;

        for (int i = 0; i < NE; i++) begin
            abuf[i] = DATA_W'($urandom);
            bbuf[i] = DATA_W'($urandom);
            cbuf[i] = SUM_W'($urandom);
        end
        m_len       = 16'(4 * N);
        m_irq_en    = 1'b0;
        m_done      = 1'b0;
        m_busy      = 1'b0;
        m_err_start = 1'b0;
        m_err_wr    = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_capture", 32'(capture_sums), 32'd0);
        chk("rst_t_ctr", 32'(t_ctr), 32'd0);
        chk("rst_ready", 32'(mmio_ready), 32'd0);
        chk("rst_rdata", mmio_rdata, 32'd0);
        rst_n = 1'b1;

        // Identification and reset-valued registers
        rd_chk("id", 16'h0000, 32'h5450_0002);
        @(negedge clk);
        chk("ready_idle", 32'(mmio_ready), 32'd0);
        chk("rdata_after", mmio_rdata, 32'd0);
        rd_chk("version", 16'h0004, 32'h0002_0000);
        rd_chk("unmapped_18", 16'h0018, 32'd0);
        rd_chk("run_len_rst", 16'h0010, {16'd0, m_len});
        rd_chk("cycles_rst", 16'h0014, 32'd0);
        rd_chk("status_rst", 16'h000C, status_exp());

        // Unmapped writes leave everything alone
        wr32(16'h0018, $urandom);
        wr32(16'h0400, $urandom);
        rd_chk("run_len_after_unmapped", 16'h0010, {16'd0, m_len});

        // Directed A[5] write
        wr32(16'h0114, 32'h0000_007F);
        chk("a5_we_a", 32'(s_we_a), 32'd1);
        chk("a5_addr_a", 32'(s_addr_a), 32'd5);
        chk("a5_wdata_a", 32'(s_wdata_a), 32'h7F);
        abuf[5] = 8'h7F;
        rd_chk("a5_read", 16'h0114, 32'h0000_007F);

        // Random A/B writes, each read back through the model buffer
        for (int i = 0; i < 8; i++) begin
            idx    = $urandom_range(0, NE - 1);
            d      = $urandom;
            pick_b = 1'($urandom_range(0, 1));
            addr   = (pick_b ? 16'h0200 : 16'h0100) + 16'(4 * idx);
            wr32(addr, d);
            chk("rnd_we_a", 32'(s_we_a), 32'(!pick_b));
            chk("rnd_we_b", 32'(s_we_b), 32'(pick_b));
            chk("rnd_addr", 32'(pick_b ? s_addr_b : s_addr_a), 32'(idx));
            chk("rnd_wdata", 32'(pick_b ? s_wdata_b : s_wdata_a),
                32'(d[DATA_W-1:0]));
            if (pick_b) bbuf[idx] = d[DATA_W-1:0];
            else        abuf[idx] = d[DATA_W-1:0];
            rd_chk("rnd_readback", addr,
                   32'(pick_b ? bbuf[idx] : abuf[idx]));
        end

        // Byte lane 0 disabled, and out-of-range element
        wrs(16'h0108, $urandom, 4'b1110);
        chk("nostrb_we_a", 32'(s_we_a), 32'd0);
        wr32(16'h0140, $urandom);
        chk("oor_we_a", 32'(s_we_a), 32'd0);
        chk("oor_we_b", 32'(s_we_b), 32'd0);
        rd_chk("oor_read_a", 16'h0140, 32'd0);
        rd_chk("oor_read_b", 16'h0240, 32'd0);

        // C readback
        for (int i = 0; i < 4; i++) begin
            idx = $urandom_range(0, NE - 1);
            rd_chk("c_read", 16'h0300 + 16'(4 * idx), cbuf[idx]);
        end

        // RUN_LEN: upper byte only, then write+read in one cycle
        d = $urandom;
        wrs(16'h0010, d, 4'b0010);
        m_len = {d[15:8], m_len[7:0]};
        rd_chk("run_len_byte1", 16'h0010, {16'd0, m_len});
        bus(1'b1, 1'b1, 16'h0010, 32'h0000_0003, 4'hF, v);
        chk("rw_returns_old", v, {16'd0, m_len});
        m_len = 16'd3;
        rd_chk("run_len_new", 16'h0010, 32'd3);

        // Directed run with interrupt enabled
        start_run(32'h5);
        run_check();

        // Randomized runs, first with length 0 (treated as 1)
        for (int r = 0; r < 4; r++) begin
            m_len = (r == 0) ? 16'd0 : 16'($urandom_range(1, 12));
            wr32(16'h0010, {16'($urandom), m_len});
            d = 32'h1 | (32'($urandom_range(0, 1)) << 1)
                      | (32'($urandom_range(0, 1)) << 2);
            start_run(d);
            run_check();
        end

        // clear_done from DONE
        start_run(32'h2);
        chk("clear_state", 32'(state), 32'd0);
        chk("clear_done", 32'(done), 32'd0);
        chk("clear_irq", 32'(irq), 32'd0);
        rd_chk("clear_status", 16'h000C, status_exp());

        // Errors while busy
        m_len = 16'd20;
        wr32(16'h0010, 32'd20);
        start_run(32'h1);
        wr32(16'h0008, 32'h1);
        m_irq_en    = 1'b0;
        m_err_start = 1'b1;
        wr32(16'h010C, 32'h0000_00A5);
        chk("busy_we_a", 32'(s_we_a), 32'd0);
        m_err_wr = 1'b1;
        wr32(16'h0010, 32'd5);
        rd_chk("busy_status", 16'h000C, status_exp());
        wr32(16'h000C, 32'hC);
        m_err_start = 1'b0;
        m_err_wr    = 1'b0;
        rd_chk("w1c_status", 16'h000C, status_exp());
        rd_chk("busy_run_len", 16'h0010, 32'd20);
        wait_done(60);
        rd_chk("err_run_cycles", 16'h0014, 32'd21);
        rd_chk("a3_unchanged", 16'h010C, 32'(abuf[3]));
        rd_chk("done_status", 16'h000C, status_exp());

        // start+clear in DONE restarts; clear alone returns to IDLE
        m_len = 16'd2;
        wr32(16'h0010, 32'd2);
        start_run(32'h7);
        chk("restart_done", 32'(done), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);
        chk("restart_state", 32'(state), 32'd1);
        wait_done(40);
        chk("restart_irq", 32'(irq), 32'(m_done & m_irq_en));
        start_run(32'h2);
        chk("idle_state", 32'(state), 32'd0);
        chk("idle_irq", 32'(irq), 32'd0);

        // Asynchronous reset in the middle of a run
        m_len = 16'd10;
        wr32(16'h0010, 32'd10);
        start_run(32'h5);
        cnt = 0;
        while (t_ctr != 16'd2 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("reached_t2", 32'(t_ctr), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_irq", 32'(irq), 32'd0);
        chk("arst_t_ctr", 32'(t_ctr), 32'd0);
        chk("arst_ready", 32'(mmio_ready), 32'd0);
        chk("arst_rdata", mmio_rdata, 32'd0);
        cnt = int'(capture_sums);
        repeat (3) begin
            @(negedge clk);
            cnt += int'(capture_sums);
        end
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            cnt += int'(capture_sums);
        end
        chk("arst_no_capture", 32'(cnt), 32'd0);
        chk("arst_idle", 32'(state), 32'd0);
        m_len       = 16'(4 * N);
        m_irq_en    = 1'b0;
        m_done      = 1'b0;
        m_busy      = 1'b0;
        m_err_start = 1'b0;
        m_err_wr    = 1'b0;
        rd_chk("arst_run_len", 16'h0010, {16'd0, m_len});
        rd_chk("arst_cycles", 16'h0014, 32'd0);
        rd_chk("arst_status", 16'h000C, status_exp());

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tpu_csr_v2.md
TPU_CSR_V2 -- requirements
Module: tpu_csr_v2

Interface
REQ-001 Parameters (name, default, meaning), one per line; N*N*4 SHALL be <= 256, DATA_W SHALL be <= 32:
  N 4 systolic array dimension
  DATA_W 8 operand element width
  SUM_W 32 accumulator width; SUM_W SHALL be <= 32 on read
  ID_VALUE 32'h5450_0002 ID register value
  VERSION_VALUE 32'h0002_0000 VERSION register value
  TPU_BASE 16'h0000 MMIO base offset
  RUN_LEN_RST 4*N reset value of RUN_LEN
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk in 1 sole clock, rising edge
  rst_n in 1 asynchronous active-low reset
  mmio_wr in 1 write request
  mmio_rd in 1 read request
  mmio_addr in 16 byte address
  mmio_wdata in 32 write data
  mmio_wstrb in 4 byte strobes
  a_flat in DATA_W*N*N A buffer contents
  b_flat in DATA_W*N*N B buffer contents
  c_flat in SUM_W*N*N C results
  mmio_rdata out 32 read data
  mmio_ready out 1 access-complete pulse
  busy out 1 run in progress
  done out 1 sticky completion
  irq out 1 level interrupt
  capture_sums out 1 single-cycle C capture strobe
  t_ctr out 16 run cycle counter
  state out 2 FSM state
  we_a, we_b out 1 buffer write strobes
  addr_a, addr_b out $clog2(N*N) element index
  wdata_a, wdata_b out DATA_W element data

Function
REQ-003 Register map (offsets from TPU_BASE), all words 4-byte aligned:
  0x00 ID (RO)
  0x04 VERSION (RO)
  0x08 CTRL: bit0 start (write-1 pulse), bit1 clear_done (write-1 pulse), bit2 irq_en (RW)
  0x0C STATUS: bit0 busy, bit1 done, bit2 err_busy_start (W1C), bit3 err_busy_wr (W1C)
  0x10 RUN_LEN (RW, 16 bits)
  0x14 CYCLES (RO)
  0x100 A, 0x200 B, 0x300 C; element i at base+4*i.
REQ-004 Unmapped reads SHALL return 0; unmapped writes SHALL be ignored without error.
REQ-005 mmio_ready SHALL pulse exactly one cycle after any cycle with mmio_wr or mmio_rd; otherwise it is 0.
REQ-006 Reads SHALL be registered: mmio_rdata is valid in the mmio_ready cycle and 0 otherwise.
REQ-007 When mmio_wr and mmio_rd coincide, the write SHALL take effect and the read SHALL return the pre-write value.
REQ-008 A/B element reads SHALL be zero-extended; C reads SHALL return c_flat element i, zero-extended.
REQ-009 we_a/we_b SHALL be combinational: mmio_wr & in-range address & mmio_wstrb[0] & !busy; addr_x = (addr-base)>>2; wdata_x = mmio_wdata[DATA_W-1:0].
REQ-010 An A/B write while busy SHALL be dropped and SHALL set err_busy_wr.
REQ-011 RUN_LEN writes SHALL be per-byte via wstrb[1:0] and SHALL be ignored while busy; an effective run length of 0 SHALL be treated as 1.
REQ-012 FSM states SHALL be IDLE=0, RUN=1, CAPT=2, DONE=3.
REQ-013 start in IDLE or DONE SHALL enter RUN with t_ctr=0, busy=1, done=0.
REQ-014 In RUN, t_ctr SHALL increment each cycle; at t_ctr==len-1 the FSM SHALL enter CAPT with busy=0 and t_ctr=0.
REQ-015 CAPT SHALL last 1 cycle with capture_sums=1, then enter DONE with done=1.
REQ-016 start during RUN or CAPT SHALL be ignored and SHALL set err_busy_start.
REQ-017 clear_done SHALL clear done; in DONE it SHALL return the FSM to IDLE.
REQ-018 start and clear_done in the same write SHALL behave as start.
REQ-019 W1C of an error bit in the same cycle as a new error SHALL leave the bit set.
REQ-020 CYCLES SHALL latch len+1 (start to done, inclusive) on entry to DONE.
REQ-021 irq SHALL equal done & irq_en (registered-state-derived, no glitch).

Reset
REQ-022 On rst_n low, asynchronously: state=IDLE; busy, done, irq, capture_sums, irq_en, errors, mmio_ready, mmio_rdata, t_ctr, CYCLES = 0; RUN_LEN=RUN_LEN_RST.
REQ-023 Reset asserted mid-RUN SHALL abort the run with no capture_sums pulse.

Verification
REQ-024 Read 0x00 -> mmio_ready 1 cycle later, rdata 0x5450_0002; read 0x18 -> 0.
REQ-025 N=4: write A[5]=0x7F at 0x114 -> we_a=1, addr_a=5; read back -> 0x0000_007F.
REQ-026 Write RUN_LEN=3, then CTRL=0x5 -> busy for 3 cycles, capture_sums 1 cycle, done=1, irq=1, CYCLES=4.
REQ-027 start while busy, then write A -> STATUS=0xD, we_a stays 0; write STATUS=0xC -> STATUS bits 2,3 clear.
REQ-028 Write CTRL=0x3 in DONE -> a new run starts, done=0; write CTRL=0x2 in DONE -> state IDLE, irq=0.
REQ-029 Drop rst_n at t_ctr=2 -> all outputs reset asynchronously; no capture_sums pulse.
